// File: rtl/alu_op_sequencer.sv
// Sequences add/sub/and/or requests through an external combinational ALU, using two passes
// for subtraction. Define ALU_SEQ_SLT_EN to make R-type funct 0010 (set-less-than) legal.
module alu_op_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_aluop,
    input  logic [3:0]  req_funct,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [63:0] alu_result,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_err
);

    localparam logic [3:0] OpAnd     = 4'b0000;
    localparam logic [3:0] OpOr      = 4'b0001;
    localparam logic [3:0] OpAdd     = 4'b0010;
    localparam logic [3:0] OpAddInvB = 4'b0110;

    typedef enum logic [1:0] {StIdle, StPass1, StPass2, StResp} state_e;
    typedef enum logic [2:0] {KindAdd, KindSub, KindAnd, KindOr, KindSlt} kind_e;

    state_e      state_q, state_d;
    kind_e       kind_q, kind_d;
    logic [63:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]  alu_op_q, alu_op_d;
    logic [63:0] res_q, res_d;
    logic        zero_q, zero_d, err_q, err_d;

    kind_e       dec_kind;
    logic        dec_legal;
    logic [3:0]  dec_op;

    always_comb begin
        dec_legal = 1'b1;
        dec_kind  = KindAdd;
        case (req_aluop)
            2'b00: dec_kind = KindAdd;
            2'b01: dec_kind = KindSub;
            2'b10: begin
                case (req_funct)
                    4'b0000: dec_kind = KindAdd;
                    4'b1000: dec_kind = KindSub;
                    4'b0111: dec_kind = KindAnd;
                    4'b0110: dec_kind = KindOr;
`ifdef ALU_SEQ_SLT_EN
                    4'b0010: dec_kind = KindSlt;
`endif
                    default: dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
        // Subtraction starts as a + ~b; the +1 is added in the second pass.
        case (dec_kind)
            KindAnd:          dec_op = OpAnd;
            KindOr:           dec_op = OpOr;
            KindSub, KindSlt: dec_op = OpAddInvB;
            default:          dec_op = OpAdd;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        res_d    = res_q;
        zero_d   = zero_q;
        err_d    = err_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (dec_legal) begin
                        kind_d   = dec_kind;
                        alu_a_d  = req_a;
                        alu_b_d  = req_b;
                        alu_op_d = dec_op;
                        state_d  = StPass1;
                    end else begin
                        res_d   = 64'd0;
                        zero_d  = 1'b0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StPass1: begin
                if (kind_q == KindSub || kind_q == KindSlt) begin
                    alu_a_d  = alu_result;
                    alu_b_d  = 64'd1;
                    alu_op_d = OpAdd;
                    state_d  = StPass2;
                end else begin
                    res_d   = alu_result;
                    zero_d  = alu_zero;
                    err_d   = 1'b0;
                    state_d = StResp;
                end
            end
            StPass2: begin
                err_d = 1'b0;
                if (kind_q == KindSlt) begin
                    res_d  = {63'b0, alu_result[63]};
                    zero_d = ~alu_result[63];
                end else begin
                    res_d  = alu_result;
                    zero_d = alu_zero;
                end
                state_d = StResp;
            end
            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            kind_q   <= KindAdd;
            alu_a_q  <= 64'd0;
            alu_b_q  <= 64'd0;
            alu_op_q <= 4'd0;
            res_q    <= 64'd0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign rsp_valid  = (state_q == StResp);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_result = res_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;

endmodule
